panxi_spsram_arb2: RTL and testbench
====================================

// Module: panxi_spsram_arb2
// PURPOSE
//  Two-requester arbiter/controller for one panxi single-port SRAM macro (1024x32 default).
//  - Shares the macro between the instruction-fetch port (I, read-only) and the data port (D, read/write, byte strobes).
//  - Drives the macro's CEN/GWEN/AWEN/AADDR/ADATA_XI pins.
//  - Returns read data to the port that issued the read, with one-cycle latency.
//  - D has priority; a bounded-wait counter prevents starvation of I.
// PARAMETERS
//  ADDR_WIDTH  10  word address width; must match the SRAM macro.
//  DATA_WIDTH  32  word width; must be a multiple of 8.
//  MAX_WAIT    4   max consecutive cycles I may be denied while requesting; range 1..15.
// PORTS
//  ACLK      in   1             clock; all state updates on the rising edge
//  ARST      in   1             asynchronous active-high reset
//  I_REQ     in   1             I read request; I_ADDR held stable until I_GNT
//  I_ADDR    in   ADDR_WIDTH    I word address
//  I_GNT     out  1             I request accepted this cycle (combinational)
//  I_RVALID  out  1             I read data valid (1-cycle pulse)
//  I_RDATA   out  DATA_WIDTH    I read data; held until the next I read completes
//  D_REQ     in   1             D request; D_WE/D_BE/D_ADDR/D_WDATA held stable until D_GNT
//  D_WE      in   1             1 = write, 0 = read
//  D_BE      in   DATA_WIDTH/8  byte enables for writes, active-high
//  D_ADDR    in   ADDR_WIDTH    D word address
//  D_WDATA   in   DATA_WIDTH    D write data
//  D_GNT     out  1             D request accepted this cycle (combinational)
//  D_RVALID  out  1             D read data valid (1-cycle pulse; never asserted for writes)
//  D_RDATA   out  DATA_WIDTH    D read data; held until the next D read completes
//  CEN       out  1             SRAM chip enable, active-low
//  AADDR     out  ADDR_WIDTH    SRAM address
//  ADATA_XI  out  DATA_WIDTH    SRAM write data
//  GWEN      out  1             SRAM global write enable, active-low
//  AWEN      out  DATA_WIDTH    SRAM per-bit write enable, active-low
//  ADATA_XO  in   DATA_WIDTH    SRAM read data; valid the cycle after a read access
// BEHAVIOUR
//  Reset (ARST=1, asynchronous)
//   - I_GNT, D_GNT, I_RVALID, D_RVALID = 0; I_RDATA, D_RDATA = 0; CEN=1; GWEN=1; AWEN = all ones.
//   - Wait counter = 0; response tag = NONE.
//   - Grants are forced to 0 while ARST is high.
//   - A read in flight when reset asserts is dropped: no RVALID follows reset release.
//  Arbitration (combinational, one access per cycle)
//   - D_REQ only -> D_GNT. I_REQ only -> I_GNT.
//   - Both requesting: D wins if wait_cnt < MAX_WAIT; otherwise I wins.
//   - At most one grant is high in any cycle.
//  Wait counter (4-bit, registered)
//   - Increments when I_REQ=1 and I_GNT=0.
//   - Clears when I_GNT=1 or I_REQ=0.
//   - Saturates at MAX_WAIT.
//   - With MAX_WAIT=1 and both ports requesting continuously, grants strictly alternate D,I,D,I...
//  SRAM drive (combinational, same cycle as grant)
//   - No grant: CEN=1, GWEN=1, AWEN all ones, AADDR/ADATA_XI don't-care.
//   - Granted access: CEN=0, AADDR = granted address.
//   - D write: GWEN=0; AWEN[8k+j] = ~D_BE[k]; ADATA_XI = D_WDATA.
//   - Any read: GWEN=1, AWEN all ones.
//   - D_WE=1 with D_BE=0 is still granted and takes an SRAM cycle, but writes no bits.
//  Response path
//   - Registered tag records which port issued a read: NONE, I or D.
//   - Cycle after the read grant: matching RVALID=1 for exactly one cycle.
//   - In that same cycle the matching RDATA = ADATA_XO (pass-through) and is captured into the port's hold register.
//   - RDATA then holds until that port's next RVALID.
//   - Back-to-back grants are legal every cycle; a new read may be granted in the same cycle as the previous response.
//   - Read-after-write to the same address in consecutive cycles returns the new data; the SRAM write completes first.
// TESTING
//  T1 reset: assert ARST mid-read (I granted the cycle before) -> I_RVALID=0, CEN=1, AWEN=32'hFFFFFFFF, I_RDATA=0.
//  T2 write/read: D write addr 10'h3FF, data 32'hDEADBEEF, BE=4'b0101, over cell 0 -> GWEN=0, AWEN=32'hFF00FF00;
//     then D read 10'h3FF -> next cycle D_RVALID=1, D_RDATA=32'h00AD00EF.
//  T3 starvation: MAX_WAIT=4, I_REQ and D_REQ held high 12 cycles -> grant sequence DDDDI DDDDI DD;
//     I_RVALID only on cycles after I_GNT.
//  T4 back-to-back: I reads 0,1,2 in consecutive cycles (memory preloaded with addr+1) -> I_RVALID high 3 cycles,
//     I_RDATA = 1,2,3; afterwards I_RDATA holds 3.
//  T5 routing: D read addr 5 granted, then I read addr 6 next cycle -> D_RVALID then I_RVALID in consecutive cycles;
//     the other port's RVALID stays 0 and its RDATA is unchanged.

Source files
------------

// File: rtl/panxi_spsram_arb2.sv
// Two-requester arbiter for one single-port SRAM macro: data port has priority,
// instruction fetch is protected from starvation by a bounded wait counter.
module panxi_spsram_arb2 #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                      aclk,
    input  logic                      arst,
    input  logic                      i_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      i_gnt,
    output logic                      i_rvalid,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [DATA_WIDTH/8-1:0]   d_be,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    output logic                      d_gnt,
    output logic                      d_rvalid,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      cen,
    output logic [ADDR_WIDTH-1:0]     aaddr,
    output logic [DATA_WIDTH-1:0]     adata_xi,
    output logic                      gwen,
    output logic [DATA_WIDTH-1:0]     awen,
    input  logic [DATA_WIDTH-1:0]     adata_xo
);

    localparam int         BE_WIDTH     = DATA_WIDTH / 8;
    localparam logic [3:0] MAX_WAIT_CNT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_I,
        TAG_D
    } tag_t;

    tag_t                  tag_q;
    tag_t                  tag_next;
    logic [3:0]            wait_cnt;
    logic [3:0]            wait_cnt_next;
    logic [DATA_WIDTH-1:0] i_hold;
    logic [DATA_WIDTH-1:0] d_hold;
    logic                  d_win;

    // D wins unless I has already been denied MAX_WAIT cycles in a row.
    always_comb begin
        d_win = d_req && (!i_req || (wait_cnt < MAX_WAIT_CNT));
        d_gnt = !arst && d_win;
        i_gnt = !arst && i_req && !d_win;
    end

    always_comb begin
        wait_cnt_next = 4'd0;
        if (i_req && !i_gnt) begin
            wait_cnt_next = (wait_cnt < MAX_WAIT_CNT) ? wait_cnt + 4'd1 : wait_cnt;
        end
    end

    // The tag remembers which port owns the read data arriving next cycle.
    always_comb begin
        tag_next = TAG_NONE;
        if (i_gnt) begin
            tag_next = TAG_I;
        end else if (d_gnt && !d_we) begin
            tag_next = TAG_D;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            tag_q    <= TAG_NONE;
            wait_cnt <= 4'd0;
        end else begin
            tag_q    <= tag_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            i_hold <= '0;
            d_hold <= '0;
        end else begin
            if (i_rvalid) i_hold <= adata_xo;
            if (d_rvalid) d_hold <= adata_xo;
        end
    end

    assign i_rvalid = (tag_q == TAG_I);
    assign d_rvalid = (tag_q == TAG_D);
    assign i_rdata  = i_rvalid ? adata_xo : i_hold;
    assign d_rdata  = d_rvalid ? adata_xo : d_hold;

    // Byte strobes expand to the macro's active-low per-bit write enables.
    always_comb begin
        cen      = 1'b1;
        gwen     = 1'b1;
        awen     = '1;
        aaddr    = d_gnt ? d_addr : i_addr;
        adata_xi = d_wdata;
        if (d_gnt) begin
            cen = 1'b0;
            if (d_we) begin
                gwen = 1'b0;
                for (int k = 0; k < BE_WIDTH; k++) begin
                    awen[8*k +: 8] = {8{~d_be[k]}};
                end
            end
        end else if (i_gnt) begin
            cen = 1'b0;
        end
    end

endmodule

// File: tb/tb_panxi_spsram_arb2.sv
// Bench for panxi_spsram_arb2: SRAM macro stub, behavioural reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_panxi_spsram_arb2;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MW = 4;

    logic          aclk = 1'b0;
    logic          arst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          cen;
    logic [AW-1:0] aaddr;
    logic [DW-1:0] adata_xi;
    logic          gwen;
    logic [DW-1:0] awen;
    logic [DW-1:0] adata_xo;

    logic          doPreload;
    logic [DW-1:0] sramMem [0:1023];
    logic [DW-1:0] refMem  [0:1023];

    int vectors     = 0;
    int miscompares = 0;

    int            denied;
    int            pend;
    logic [DW-1:0] pendData;
    logic [DW-1:0] iHold;
    logic [DW-1:0] dHold;
    logic          expI;
    logic          expD;
    logic [DW-1:0] bitMask;

    panxi_spsram_arb2 #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (MW)
    ) dut (
        .aclk    (aclk),
        .arst    (arst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_rvalid(i_rvalid),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_be    (d_be),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .cen     (cen),
        .aaddr   (aaddr),
        .adata_xi(adata_xi),
        .gwen    (gwen),
        .awen    (awen),
        .adata_xo(adata_xo)
    );

    always #5 aclk = ~aclk;

    // SRAM macro stub: bit-masked write, registered read data.
    always @(posedge aclk) begin
        if (doPreload) begin
            for (int a = 0; a < 1024; a++) sramMem[a] <= (a == 1023) ? '0 : DW'(a + 1);
        end else if (!cen) begin
            if (!gwen) sramMem[aaddr] <= (sramMem[aaddr] & awen) | (adata_xi & ~awen);
            else       adata_xo <= sramMem[aaddr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [AW-1:0] ia, input logic dr,
                                 input logic dw, input logic [BW-1:0] db,
                                 input logic [AW-1:0] da, input logic [DW-1:0] dd);
        @(posedge aclk);
        #1;
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_be    = db;
        d_addr  = da;
        d_wdata = dd;
        @(negedge aclk);
    endtask

    // Reference model: memory image, pending read owner, per-port hold values.
    initial begin
        for (int a = 0; a < 1024; a++) refMem[a] = (a == 1023) ? '0 : DW'(a + 1);
        denied = 0; pend = 0; pendData = '0; iHold = '0; dHold = '0;
        forever begin
            @(negedge aclk);
            if (arst) begin
                checkOutput("rst_i_gnt",    32'(i_gnt),    32'd0);
                checkOutput("rst_d_gnt",    32'(d_gnt),    32'd0);
                checkOutput("rst_i_rvalid", 32'(i_rvalid), 32'd0);
                checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);
                checkOutput("rst_i_rdata",  i_rdata,       32'd0);
                checkOutput("rst_d_rdata",  d_rdata,       32'd0);
                checkOutput("rst_cen",      32'(cen),      32'd1);
                checkOutput("rst_gwen",     32'(gwen),     32'd1);
                checkOutput("rst_awen",     awen,          32'hFFFFFFFF);
                denied = 0; pend = 0; iHold = '0; dHold = '0;
            end else begin
                if (pend == 1) iHold = pendData;
                if (pend == 2) dHold = pendData;
                checkOutput("m_i_rvalid", 32'(i_rvalid), 32'(pend == 1));
                checkOutput("m_d_rvalid", 32'(d_rvalid), 32'(pend == 2));
                checkOutput("m_i_rdata",  i_rdata, iHold);
                checkOutput("m_d_rdata",  d_rdata, dHold);
                expD = d_req && (!i_req || denied < MW);
                expI = i_req && !expD;
                checkOutput("m_i_gnt", 32'(i_gnt), 32'(expI));
                checkOutput("m_d_gnt", 32'(d_gnt), 32'(expD));
                checkOutput("m_cen",   32'(cen),   32'(!(expI || expD)));
                for (int k = 0; k < BW; k++) bitMask[8*k +: 8] = d_be[k] ? 8'hFF : 8'h00;
                if (expD && d_we) begin
                    checkOutput("m_gwen",     32'(gwen), 32'd0);
                    checkOutput("m_awen",     awen,      ~bitMask);
                    checkOutput("m_adata_xi", adata_xi,  d_wdata);
                    checkOutput("m_aaddr",    32'(aaddr), 32'(d_addr));
                end else begin
                    checkOutput("m_gwen", 32'(gwen), 32'd1);
                    checkOutput("m_awen", awen,      32'hFFFFFFFF);
                    if (expI || expD) checkOutput("m_aaddr", 32'(aaddr), 32'(expD ? d_addr : i_addr));
                end
                pend = 0;
                if (expI) begin
                    pend = 1; pendData = refMem[i_addr];
                end else if (expD && !d_we) begin
                    pend = 2; pendData = refMem[d_addr];
                end else if (expD) begin
                    refMem[d_addr] = (refMem[d_addr] & ~bitMask) | (d_wdata & bitMask);
                end
                denied = (i_req && !expI) ? ((denied < MW) ? denied + 1 : MW) : 0;
            end
        end
    end

    // Directed scenarios with hand-computed values, then random traffic.
    initial begin
        logic [11:0] expDPat;
        logic        iGntSeen;
        logic        dGntSeen;
        arst = 1'b1; doPreload = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge aclk);
        #1;
        doPreload = 1'b0;
        arst      = 1'b0;

        applyStimulus(1'b0, '0, 1'b1, 1'b1, 4'b0101, 10'h3FF, 32'hDEADBEEF);
        checkOutput("t2_d_gnt", 32'(d_gnt), 32'd1);
        checkOutput("t2_gwen",  32'(gwen),  32'd0);
        checkOutput("t2_awen",  awen,       32'hFF00FF00);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'b0000, 10'h3FF, 32'h0);
        checkOutput("t2_rd_gnt", 32'(d_gnt), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'b0000, '0, 32'h0);
        checkOutput("t2_d_rvalid", 32'(d_rvalid), 32'd1);
        checkOutput("t2_d_rdata",  d_rdata,        32'h00AD00EF);

        applyStimulus(1'b1, 10'd0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("t4_c0_i_rvalid", 32'(i_rvalid), 32'd0);
        applyStimulus(1'b1, 10'd1, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("t4_c1_i_rvalid", 32'(i_rvalid), 32'd1);
        checkOutput("t4_c1_i_rdata",  i_rdata,        32'd1);
        applyStimulus(1'b1, 10'd2, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("t4_c2_i_rvalid", 32'(i_rvalid), 32'd1);
        checkOutput("t4_c2_i_rdata",  i_rdata,        32'd2);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("t4_c3_i_rvalid", 32'(i_rvalid), 32'd1);
        checkOutput("t4_c3_i_rdata",  i_rdata,        32'd3);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("t4_hold_i_rvalid", 32'(i_rvalid), 32'd0);
        checkOutput("t4_hold_i_rdata",  i_rdata,        32'd3);

        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 10'd5, '0);
        checkOutput("t5_d_gnt", 32'(d_gnt), 32'd1);
        applyStimulus(1'b1, 10'd6, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("t5_d_rvalid", 32'(d_rvalid), 32'd1);
        checkOutput("t5_d_rdata",  d_rdata,        32'd6);
        checkOutput("t5_i_rvalid0", 32'(i_rvalid), 32'd0);
        checkOutput("t5_i_rdata_kept", i_rdata,     32'd3);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("t5_i_rvalid", 32'(i_rvalid), 32'd1);
        checkOutput("t5_i_rdata",  i_rdata,        32'd7);
        checkOutput("t5_d_rvalid0", 32'(d_rvalid), 32'd0);
        checkOutput("t5_d_rdata_kept", d_rdata,     32'd6);

        expDPat = 12'b111101111011;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, 10'd20, 1'b1, 1'b0, '0, 10'd30, '0);
            checkOutput("t3_d_gnt", 32'(d_gnt), 32'(expDPat[11-c]));
            checkOutput("t3_i_gnt", 32'(i_gnt), 32'(!expDPat[11-c]));
            checkOutput("t3_i_rvalid", 32'(i_rvalid), (c == 0) ? 32'd0 : 32'(!expDPat[12-c]));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        applyStimulus(1'b1, 10'd7, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("t1_i_gnt", 32'(i_gnt), 32'd1);
        @(posedge aclk);
        #1;
        arst  = 1'b1;
        i_req = 1'b0;
        @(negedge aclk);
        checkOutput("t1_i_rvalid", 32'(i_rvalid), 32'd0);
        checkOutput("t1_cen",      32'(cen),      32'd1);
        checkOutput("t1_awen",     awen,          32'hFFFFFFFF);
        checkOutput("t1_i_rdata",  i_rdata,       32'd0);
        @(posedge aclk);
        #1;
        arst = 1'b0;
        @(negedge aclk);
        checkOutput("t1_no_rvalid", 32'(i_rvalid), 32'd0);

        iGntSeen = 1'b1;
        dGntSeen = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(posedge aclk);
            #1;
            if (arst) arst = 1'b0;
            else if ($urandom_range(0, 299) == 0) arst = 1'b1;
            if (!i_req || iGntSeen) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = AW'($urandom_range(0, 15));
            end
            if (!d_req || dGntSeen) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_be    = BW'($urandom_range(0, 15));
                d_addr  = AW'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            @(negedge aclk);
            iGntSeen = i_gnt;
            dGntSeen = d_gnt;
        end

        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
